// File: rtl/vermi_spi.sv
// vermi_spi
// ---------
// Memory-mapped SPI master (mode 0, MSB first) for one Vermibus device slot.
// The CPU writes a byte to DATA. The block shifts it out on mosi and shifts a
// byte in from miso at the same time. Completion sets a sticky done flag, and
// irq stays asserted while both done and irq_en are set.
//
// Register map, selected by address[3:2]:
//   0 DATA   : read {24'b0, rx}; a write with wstrobe[0] starts a transfer if idle
//   1 CTRL   : {16'b0, div, 6'b0, cs, irq_en}
//   2 STATUS : {30'b0, done, busy}; writing bit 1 (wstrobe[0]) clears done
//   3        : reads 0, writes ignored
// A DATA read also clears done.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   valid    in   bus request, already qualified by the device select
//   ready    out  bus response, equal to valid (zero wait states)
//   address  in   byte address, only [3:2] decoded
//   wstrobe  in   byte write enables, all-zero means read
//   wdata    in   write data
//   rdata    out  read data (combinational)
//   irq      out  done & irq_en
//   sclk     out  SPI clock, idle low
//   mosi     out  SPI data out, shift[7]
//   miso     in   SPI data in, assumed synchronous to clk
//   cs_n     out  chip select, software controlled through CTRL.cs

module vermi_spi #(
    parameter logic [7:0] DIV_RESET = 8'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    output logic        ready,
    input  logic [31:0] address,
    input  logic [3:0]  wstrobe,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t      state_q;
    logic [7:0]  shift_q;
    logic [7:0]  rx_q;
    logic [7:0]  div_q;
    logic [7:0]  divActive_q;
    logic [7:0]  hcnt_q;
    logic [3:0]  edges_q;
    logic        sclk_q;
    logic        rxbit_q;
    logic        busy_q;
    logic        done_q;
    logic        done_d;
    logic        cs_q;
    logic        irqEn_q;

    logic [1:0]  regIdx;
    logic        isWrite;
    logic        isRead;
    logic        startXfer;
    logic        ctrlLoWr;
    logic        ctrlHiWr;
    logic        doneClr;
    logic        halfTick;
    logic        lastEdge;
    logic [7:0]  shiftNext;

    // Address and data bits that the register map never looks at.
    logic        unusedBits;
    assign unusedBits = ^{address[31:4], address[1:0], wdata[31:16]};

    // Bus decode. A transfer may only start while busy reads 0, so a DATA
    // write landing on the very edge where a transfer ends is still dropped.
    always_comb begin
        regIdx    = address[3:2];
        isWrite   = valid && (wstrobe != 4'b0000);
        isRead    = valid && (wstrobe == 4'b0000);
        startXfer = isWrite && (regIdx == 2'd0) && wstrobe[0] && !busy_q;
        ctrlLoWr  = isWrite && (regIdx == 2'd1) && wstrobe[0];
        ctrlHiWr  = isWrite && (regIdx == 2'd1) && wstrobe[1];
        doneClr   = (isWrite && (regIdx == 2'd2) && wstrobe[0] && wdata[1])
                  || (isRead && (regIdx == 2'd0));
        halfTick  = (state_q == SHIFT) && (hcnt_q == divActive_q);
        lastEdge  = halfTick && sclk_q && (edges_q == 4'd15);
        shiftNext = {shift_q[6:0], rxbit_q};
        // Completion wins over a software clear in the same cycle so that a
        // finished transfer can never go unreported.
        if (lastEdge) begin
            done_d = 1'b1;
        end else if (doneClr) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
    end

    // Register state and the shift engine. The half-period counter runs
    // 0..divActive, so each sclk phase lasts divActive+1 clocks; miso is
    // captured on the rising sclk edge and shifted in on the falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shift_q     <= 8'd0;
            rx_q        <= 8'd0;
            div_q       <= DIV_RESET;
            divActive_q <= 8'd0;
            hcnt_q      <= 8'd0;
            edges_q     <= 4'd0;
            sclk_q      <= 1'b0;
            rxbit_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cs_q        <= 1'b0;
            irqEn_q     <= 1'b0;
        end else begin
            if (ctrlLoWr) begin
                irqEn_q <= wdata[0];
                cs_q    <= wdata[1];
            end
            if (ctrlHiWr) begin
                div_q <= wdata[15:8];
            end
            done_q <= done_d;

            case (state_q)
                IDLE: begin
                    sclk_q  <= 1'b0;
                    hcnt_q  <= 8'd0;
                    edges_q <= 4'd0;
                    if (startXfer) begin
                        shift_q     <= wdata[7:0];
                        divActive_q <= div_q;
                        busy_q      <= 1'b1;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (halfTick) begin
                        hcnt_q  <= 8'd0;
                        sclk_q  <= ~sclk_q;
                        edges_q <= edges_q + 4'd1;
                        if (!sclk_q) begin
                            rxbit_q <= miso;
                        end else begin
                            shift_q <= shiftNext;
                            if (lastEdge) begin
                                rx_q    <= shiftNext;
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end
                        end
                    end else begin
                        hcnt_q <= hcnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Read mux and pin outputs; everything driven off-chip comes from a register.
    always_comb begin
        case (regIdx)
            2'd0:    rdata = {24'd0, rx_q};
            2'd1:    rdata = {16'd0, div_q, 6'd0, cs_q, irqEn_q};
            2'd2:    rdata = {30'd0, done_q, busy_q};
            default: rdata = 32'd0;
        endcase
    end

    assign ready = valid;
    assign irq   = done_q & irqEn_q;
    assign sclk  = sclk_q;
    assign mosi  = shift_q[7];
    assign cs_n  = ~cs_q;

endmodule

// File: doc/vermi_spi.md
# vermi_spi

Memory-mapped SPI master peripheral on the Vermibus response side. It occupies one device slot behind the CPU address decoder, in the same way as the timer and UART. The CPU writes a byte, and the block shifts it out MSB-first in SPI mode 0 while shifting in a byte from MISO. Completion is reported through a sticky status flag and an optional level interrupt that the decoder ORs onto the CPU `irq`.

## Interface
- `DIV_RESET`, default 8'd3: reset value of the clock divider field.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid`  in  1  bus request; already qualified by the device-select decode.
- `ready`  out  1  bus response; combinational, equals `valid`.
- `address`  in  32  byte address; only `address[3:2]` is decoded.
- `wstrobe`  in  4  byte write enables; all-zero means read.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; combinational, valid while `ready`=1.
- `irq`  out  1  interrupt, equal to `done & irq_en`.
- `sclk`  out  1  SPI clock; idle low.
- `mosi`  out  1  SPI data out, always equal to `shift[7]`.
- `miso`  in  1  SPI data in; assumed synchronous to `clk`, no synchronizer.
- `cs_n`  out  1  chip select, equal to `~cs`; software controlled.

## Operation
Registers, selected by `address[3:2]`:
- **0 DATA**
  - Read: `{24'b0, rx}`.
  - Write with `wstrobe[0]=1` while `busy`=0: loads `shift`←`wdata[7:0]`, latches `div_active`←`div`, sets `busy`, starts a transfer.
  - Write while `busy`=1: ignored.
- **1 CTRL**
  - Read: `{16'b0, div, 6'b0, cs, irq_en}`.
  - `wstrobe[0]` writes `irq_en`←`wdata[0]` and `cs`←`wdata[1]`.
  - `wstrobe[1]` writes `div`←`wdata[15:8]`.
  - Writes are accepted at any time. A `div` change takes effect from the next transfer only.
- **2 STATUS**
  - Read: `{30'b0, done, busy}`.
  - A write with `wstrobe[0]=1` and `wdata[1]=1` clears `done`.
- **3:** reads 0; writes ignored.

A read of DATA (`valid`, `wstrobe`=0, index 0) also clears `done`.

State machine:
- **IDLE**
  - `sclk`=0, `hcnt`=0, `edges`=0.
  - A DATA write moves to SHIFT.
- **SHIFT**
  - `hcnt` counts 0..`div_active`. When `hcnt`=`div_active`, `hcnt`←0, `sclk` toggles and `edges` increments. `edges` is 4 bits.
  - Rising edge (`sclk` 0→1): `rxbit`←`miso`.
  - Falling edge (`sclk` 1→0): `shift`←`{shift[6:0], rxbit}`.
  - On the 16th toggle (8th falling edge): `rx`←`{shift[6:0], rxbit}`, `busy`←0, `done`←1, return to IDLE.

Rules:
- `done` set has priority over any clear in the same cycle.
- `cs_n` is never driven by the state machine.
- `rx` holds its value until the next transfer completes.

Reset values:
- `sclk`=0, `mosi`=0 (`shift`=0), `cs_n`=1 (`cs`=0).
- `irq`=0, `irq_en`=0, `busy`=0, `done`=0.
- `rx`=0, `div`=`DIV_RESET`, state IDLE.

## Timing
- Bus: zero wait states. `ready`=`valid` in the same cycle. Writes commit at the rising edge that ends the request cycle.
- With the DATA write committing at edge E0 and H = `div_active`+1:
  - `busy` reads 1 from the cycle after E0.
  - `mosi` carries bit 7 from E0.
  - `sclk` rises at E0+H·(2k+1) and falls at E0+H·(2k+2), for k = 0..7.
- Transfer ends at E0+16·H:
  - `busy`=0, `done`=1, `rx` valid.
  - `irq` is asserted from the cycle after that edge if `irq_en`=1.
- Minimum transfer (`div`=0) takes 16 clk cycles; maximum (`div`=255) takes 4096.
- A DATA write in the cycle where `busy` still reads 1 is dropped, even if the transfer completes at that same edge.
- Reset asserted mid-transfer aborts immediately and asynchronously to the reset values. No partial `rx` update occurs.

## Test plan
- **Reset:** hold `reset`=0 with activity on `miso`/`valid` → `sclk`=0, `cs_n`=1, `irq`=0. CTRL reads 0x0000_0300 with `DIV_RESET`=3.
- **Loopback, `div`=0:**
  - Stimulus: tie `miso`=`mosi`, write DATA=0xA5.
  - Response: exactly 8 `sclk` pulses, each 1 cycle high and 1 cycle low; `busy` high for 16 cycles. After that, STATUS=0x2 and DATA reads 0xA5. STATUS reads 0x0 after the DATA read.
- **Divider and pattern:**
  - Stimulus: CTRL=0x0000_0203 (`div`=2, `cs`=1, `irq_en`=1), `cs_n`=0; slave drives 0x3C on `miso` while DATA=0x81 is sent.
  - Response: `sclk` half-period 3 cycles; MOSI bits 1,0,0,0,0,0,0,1. At E0+48, `irq`=1 and DATA reads 0x3C.
- **Busy collision:** write DATA=0x11, then DATA=0x22 four cycles later → the second write is ignored; received shift order reflects 0x11 only; one `done`.
- **Done/IRQ priority:**
  - Stimulus: write STATUS=0x2 in the same cycle the transfer completes.
  - Response: `done` remains 1. A later STATUS=0x2 write clears it and `irq` drops.
- **Reset mid-transfer:** assert `reset` after 3 `sclk` rises → all outputs return to reset values. `rx` stays at its previous value of 0, and a new transfer completes normally after release.
